auto_encoder_test: RTL

AUTO_ENCODER_TEST -- requirements
Module: auto_encoder_test

---
 rtl/auto_encoder_test.sv | 137 +++++++++++++
 1 files changed

// File: rtl/auto_encoder_test.sv
// auto_encoder_test: self-running stimulus sweep for an 8-to-3 priority
// encoder. On start it walks a one-hot pattern from bit 0 to bit 7, holding
// each value for DIV cycles. It encodes the pattern one cycle later and checks
// the encoded result against the step index on every step boundary. Any
// disagreement sets a sticky err flag.
// Optional build macro AUTO_ENCODER_TEST_ZERO_EN adds a leading all-zero
// phase (step 8). That phase checks that an empty pattern encodes as
// code 0 with valid low.
module auto_encoder_test #(
  parameter int DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic [7:0] pattern,
  output logic [2:0] code,
  output logic       valid,
  output logic [3:0] step,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [15:0] DIV_LAST  = 16'(DIV - 1);
  localparam logic [3:0]  STEP_LAST = 4'd7;
  localparam logic [3:0]  STEP_ZERO = 4'd8;

  state_t      state, state_nxt;
  logic [15:0] div_cnt;
  logic        launch;
  logic        tick;
  logic [7:0]  pattern_p0;
  logic [3:0]  step_p0;
  logic [2:0]  code_p1;
  logic        vld_p1;
  logic        err_q;

  // Highest set bit wins; an all-zero input encodes as 0.
  function automatic logic [2:0] prio_enc(input logic [7:0] p);
    logic [2:0] e;
    e = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (p[i]) e = 3'(i);
    end
    return e;
  endfunction

  // On a step boundary, decide if the encoder output disagrees with what the
  // current step should have produced (step 8 = empty pattern expected).
  function automatic logic step_mismatch(input logic [3:0] s,
                                         input logic [2:0] c,
                                         input logic       v);
    if (s == STEP_ZERO) return (c != 3'd0) || v;
    return (c != s[2:0]) || !v;
  endfunction

  assign launch = start && (state != RUN);
  assign tick   = (state == RUN) && (div_cnt == DIV_LAST);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic: start is only honoured outside RUN
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start) state_nxt = RUN;
      RUN:        if (tick && step_p0 == STEP_LAST) state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  // State-decoded status outputs
  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  // Stage p0: divider, pattern/step generation and sticky error check
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt    <= 16'd0;
      pattern_p0 <= 8'h00;
      step_p0    <= 4'd0;
      err_q      <= 1'b0;
    end else if (launch) begin
      div_cnt <= 16'd0;
      err_q   <= 1'b0;
`ifdef AUTO_ENCODER_TEST_ZERO_EN
      pattern_p0 <= 8'h00;
      step_p0    <= STEP_ZERO;
`else
      pattern_p0 <= 8'h01;
      step_p0    <= 4'd0;
`endif
    end else if (state == RUN) begin
      if (tick) begin
        div_cnt <= 16'd0;
        err_q   <= err_q | step_mismatch(step_p0, code_p1, vld_p1);
        if (step_p0 == STEP_ZERO) begin
          pattern_p0 <= 8'h01;
          step_p0    <= 4'd0;
        end else if (step_p0 != STEP_LAST) begin
          pattern_p0 <= {pattern_p0[6:0], 1'b0};
          step_p0    <= step_p0 + 4'd1;
        end else begin
          pattern_p0 <= 8'h00;
        end
      end else begin
        div_cnt <= div_cnt + 16'd1;
      end
    end
  end

  // Stage p1: registered priority encode of the current pattern
  always_ff @(posedge clk) begin
    if (rst) begin
      code_p1 <= 3'd0;
      vld_p1  <= 1'b0;
    end else begin
      code_p1 <= prio_enc(pattern_p0);
      vld_p1  <= |pattern_p0;
    end
  end

  assign pattern = pattern_p0;
  assign step    = step_p0;
  assign code    = code_p1;
  assign valid   = vld_p1;
  assign err     = err_q;

endmodule
